regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port GPR file with write-through bypass and a per-register busy scoreboard.
//   Sits in the decode stage of the dual-issue pipeline: NREAD read ports for operands,
//   NWRITE writeback ports, and issue-side busy marking for RAW hazard detection.
//   Register 0 is hardwired to zero and is never busy.
// PARAMETERS
//   WIDTH   32  data width of each register
//   NREG    32  number of architectural registers (power of 2, >= 2)
//   NREAD   4   number of read ports
//   NWRITE  2   number of write ports; a higher port index has higher priority
//   AW      $clog2(NREG)  address width (derived; do not override)
// PORTS
//   clk      in   1               clock; all state updates on its rising edge
//   reset    in   1               synchronous, active-high reset
//   ra       in   NREAD*AW        read addresses, packed [NREAD-1:0][AW-1:0]
//   rd       out  NREAD*WIDTH     read data, packed [NREAD-1:0][WIDTH-1:0]
//   rbusy    out  NREAD           register at ra[i] has a pending write
//   we       in   NWRITE          write enables
//   wa       in   NWRITE*AW       write addresses
//   wd       in   NWRITE*WIDTH    write data
//   set_busy in   NWRITE          issue marks sa[j] busy
//   sa       in   NWRITE*AW       issue destination addresses
//   flush    in   1               clear every busy bit (pipeline squash)
// BEHAVIOUR
//   State: regs[NREG-1:1] (WIDTH each) and busy[NREG-1:1]. Address 0 has no storage.
//   Reset: reset=1 at a rising edge clears all regs and all busy bits. Reset overrides
//     every we, set_busy and flush in the same cycle. While reset=1, rd=0 and rbusy=0
//     on all ports (combinational).
//   Next-state write: for each r != 0, regs_nxt[r] = wd[j], where j is the highest
//     index with we[j] && wa[j]==r. If no such j, regs_nxt[r] = regs[r].
//     Writes to address 0 are ignored.
//   Read (combinational, 0-cycle latency): rd[i] = (ra[i]==0) ? 0 : regs_nxt[ra[i]].
//     A same-cycle write is therefore visible to the reader (write-through bypass).
//     Any number of ports may read the same address.
//   Busy next-state for each r != 0, applied in this priority order:
//     1. flush=1 -> 0
//     2. else any set_busy[j] && sa[j]==r -> 1
//     3. else any we[j] && wa[j]==r -> 0
//     4. else hold
//     A set and a write to the same register in the same cycle leave it busy
//     (a new producer was issued).
//   rbusy[i] = (ra[i]==0) ? 0 : busy_nxt[ra[i]], so a same-cycle writeback clears the
//     hazard seen by decode, consistent with the bypassed rd.
//   set_busy to address 0 is ignored. Two sets to the same register in one cycle are
//     idempotent.
//   No handshake: every port is valid on every cycle, and all updates commit at the next
//     rising edge. No X may propagate from unused ports whose enables are 0.
// TESTING
//   1. Reset, then read all 32 regs on 4 ports -> rd=0, rbusy=0 everywhere.
//   2. we[0]=1, wa[0]=5, wd[0]=32'hDEAD_BEEF, ra[0]=5 in the same cycle -> rd[0]=DEADBEEF
//      that cycle; next cycle, with we=0 -> rd[0]=DEADBEEF.
//   3. Both write ports target reg 7 (wd[0]=1, wd[1]=2) -> rd reads 2 in that cycle
//      and afterwards.
//   4. Write wa=0, wd=32'hFFFF_FFFF; set_busy sa=0 -> rd for ra=0 is 0, rbusy=0.
//   5. set_busy sa=9; next cycle ra=9 -> rbusy=1. Then we wa=9 -> rbusy=0 that cycle.
//      Then set_busy and we both on reg 9 in one cycle -> busy stays 1.
//   6. Regs 3 and 4 busy with nonzero data; assert flush -> all busy=0, data kept.
//      Assert reset together with we wa=3 -> reg 3 reads 0 after the edge.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port general-purpose register file for the decode stage.
// Reads are combinational and see this cycle's writebacks (write-through bypass).
// A busy bit per register tracks pending producers for RAW hazard detection.
// Register 0 has no storage. It always reads as zero and is never busy.
module regfile_mp #(
  parameter int WIDTH  = 32,
  parameter int NREG   = 32,
  parameter int NREAD  = 4,
  parameter int NWRITE = 2,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NREAD-1:0][AW-1:0]       ra,
  output logic [NREAD-1:0][WIDTH-1:0]    rd,
  output logic [NREAD-1:0]               rbusy,
  input  logic [NWRITE-1:0]              we,
  input  logic [NWRITE-1:0][AW-1:0]      wa,
  input  logic [NWRITE-1:0][WIDTH-1:0]   wd,
  input  logic [NWRITE-1:0]              set_busy,
  input  logic [NWRITE-1:0][AW-1:0]      sa,
  input  logic                           flush
);

  // Storage exists only for registers 1..NREG-1.
  logic [WIDTH-1:0] regs_q [1:NREG-1];
  logic [WIDTH-1:0] regs_d [1:NREG-1];
  logic [NREG-1:1]  busy_q;
  logic [NREG-1:1]  busy_d;

  // Data next-state: the last matching write port in ascending order has the highest index and wins.
  always_comb begin
    for (int r = 1; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && (wa[j] == AW'(r))) begin
          regs_d[r] = wd[j];
        end else begin
          regs_d[r] = regs_d[r];
        end
      end
    end
  end

  // Busy next-state. Flush beats a new issue, and a new issue beats a writeback clear.
  always_comb begin
    for (int r = 1; r < NREG; r++) begin
      logic set_hit;
      logic wr_hit;
      set_hit = 1'b0;
      wr_hit  = 1'b0;
      for (int j = 0; j < NWRITE; j++) begin
        if (set_busy[j] && (sa[j] == AW'(r))) begin
          set_hit = 1'b1;
        end else begin
          set_hit = set_hit;
        end
        if (we[j] && (wa[j] == AW'(r))) begin
          wr_hit = 1'b1;
        end else begin
          wr_hit = wr_hit;
        end
      end
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (set_hit) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
  end

  // Read ports look up the next-state view so decode sees same-cycle writebacks and busy changes.
  // The port is decoded with a compare loop, so address 0 and out-of-range indices never touch the storage array.
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rd[i]    = '0;
      rbusy[i] = 1'b0;
      if (!reset) begin
        for (int r = 1; r < NREG; r++) begin
          if (ra[i] == AW'(r)) begin
            rd[i]    = regs_d[r];
            rbusy[i] = busy_d[r];
          end else begin
            rd[i]    = rd[i];
            rbusy[i] = rbusy[i];
          end
        end
      end else begin
        rd[i]    = '0;
        rbusy[i] = 1'b0;
      end
    end
  end

  // State commit. Synchronous reset overrides every write, set and flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 1; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

endmodule
